select_key_event: RTL and testbench

- Parametrised successor to the fixed 4-button arrow selector.
- Takes NUM_KEYS raw, asynchronous push-button inputs and passes them through a 2-flop synchroniser and a per-key debouncer.
- A press/release state machine then emits one single-cycle click per clean single-key press, with the encoded key index.
- Sits between the board buttons and the Simon Says game controller, which compares player input against the stored sequence.

---
 rtl/select_key_event.sv | 166 ++++++++++++++++
 tb/tb_select_key_event.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/select_key_event.sv
// Push-button front end: 2-flop synchroniser, per-key debouncer and a press/release FSM
// that emits one click per clean single-key press. Optional AUTO_REPEAT_EN adds held-key repeats.
module select_key_event #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned KEY_W           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_PERIOD   = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                enable,
  output logic [KEY_W-1:0]    direction_out,
  output logic                clicked,
  output logic                held,
  output logic                error_multi
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] HELD         = 2'd1;
  localparam logic [1:0] WAIT_RELEASE = 2'd2;

  if (NUM_KEYS < 2 || (2 ** KEY_W) < NUM_KEYS || DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1)
  begin : g_bad_params
    $error("select_key_event: illegal parameter set");
  end

  logic [NUM_KEYS-1:0] s1_q, s1_d, s2_q, s2_d, deb_q, deb_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  logic [1:0]          state_q, state_d;
  logic [KEY_W-1:0]    dir_q, dir_d;
  logic [NUM_KEYS-1:0] key_mask_q, key_mask_d;
  logic                clicked_q, clicked_d, held_q, held_d, err_q, err_d;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_PERIOD - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  // Synchroniser and debouncer: a level change must persist DEBOUNCE_CYCLES cycles
  always_comb begin
    s1_d  = keys;
    s2_d  = s1_q;
    deb_d = deb_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = s2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  logic                deb_onehot;
  logic                key_down;
  logic [KEY_W-1:0]    deb_idx;

  always_comb begin
    deb_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (deb_q[i]) deb_idx = KEY_W'(i);
    end
  end

  assign deb_onehot = (deb_q != '0) && ((deb_q & (deb_q - NUM_KEYS'(1))) == '0);
  // The accepted key is tracked as a mask so no out-of-range index is ever formed
  assign key_down   = |(deb_q & key_mask_q);

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    key_mask_d = key_mask_q;
    clicked_d  = 1'b0;
    held_d     = held_q;
    err_d      = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep_d      = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable && (deb_q != '0)) begin
          if (deb_onehot) begin
            dir_d      = deb_idx;
            key_mask_d = deb_q;
            clicked_d  = 1'b1;
            held_d     = 1'b1;
            state_d    = HELD;
`ifdef AUTO_REPEAT_EN
            rep_d      = '0;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_RELEASE;
          end
        end
      end
      HELD: begin
        if (!key_down) begin
          held_d  = 1'b0;
          state_d = (deb_q == '0) ? IDLE : WAIT_RELEASE;
        end
`ifdef AUTO_REPEAT_EN
        else if (enable) begin
          if (rep_q == REP_LAST) begin
            clicked_d = 1'b1;
            rep_d     = '0;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end
`endif
      end
      WAIT_RELEASE: begin
        if (deb_q == '0) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        held_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
      state_q    <= IDLE;
      dir_q      <= '0;
      key_mask_q <= '0;
      clicked_q  <= 1'b0;
      held_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_q      <= '0;
`endif
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
      state_q    <= state_d;
      dir_q      <= dir_d;
      key_mask_q <= key_mask_d;
      clicked_q  <= clicked_d;
      held_q     <= held_d;
      err_q      <= err_d;
`ifdef AUTO_REPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  assign direction_out = dir_q;
  assign clicked       = clicked_q;
  assign held          = held_q;
  assign error_multi   = err_q;

endmodule

// File: tb/tb_select_key_event.sv
// Directed bench for select_key_event (DEBOUNCE_CYCLES=4, REPEAT_PERIOD=8); edge numbers
// count posedges after a stimulus change, outputs sampled 1 time unit after each edge.
module tb_select_key_event;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] keys;
  logic       enable;
  logic [1:0] direction_out;
  logic       clicked, held, error_multi;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no, clicks, errs, first_click, last_click, first_err, held_fall;
  logic held_prev;

  select_key_event #(
    .NUM_KEYS(4), .KEY_W(2), .DEBOUNCE_CYCLES(4), .REPEAT_PERIOD(8)
  ) dut (
    .clock(clock), .reset(reset), .keys(keys), .enable(enable),
    .direction_out(direction_out), .clicked(clicked), .held(held),
    .error_multi(error_multi)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    edge_no = 0; clicks = 0; errs = 0;
    first_click = 0; last_click = 0; first_err = 0; held_fall = 0;
    held_prev = held;
  endtask

  task automatic start(input logic [3:0] v);
    @(posedge clock);
    #1;
    keys = v;
    clear_stats();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      edge_no++;
      if (clicked) begin
        clicks++;
        if (first_click == 0) first_click = edge_no;
        last_click = edge_no;
      end
      if (error_multi) begin
        errs++;
        if (first_err == 0) first_err = edge_no;
      end
      if (held_prev && !held && held_fall == 0) held_fall = edge_no;
      held_prev = held;
    end
  endtask

  initial begin
    reset = 1'b1; keys = 4'b0000; enable = 1'b1;
    #12;
    check_eq("rst_clicked", int'(clicked), 0);
    check_eq("rst_held", int'(held), 0);
    check_eq("rst_dir", int'(direction_out), 0);
    check_eq("rst_err", int'(error_multi), 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // single press of RIGHT, enable dropped while held, then release
    start(4'b0010);
    run(8);
    check_eq("s1_clicks", clicks, 1);
    check_eq("s1_click_edge", first_click, 7);
    check_eq("s1_dir", int'(direction_out), 1);
    check_eq("s1_held", int'(held), 1);
    enable = 1'b0;
    run(12);
    check_eq("s1_hold_clicks", clicks, 1);
    check_eq("s1_hold_errs", errs, 0);
    start(4'b0000);
    run(10);
    check_eq("s1_held_fall_edge", held_fall, 7);
    check_eq("s1_rel_clicks", clicks, 0);
    enable = 1'b1;

    // 3-cycle glitch on LEFT is filtered
    start(4'b1000);
    run(3);
    keys = 4'b0000;
    run(12);
    check_eq("s2_clicks", clicks, 0);
    check_eq("s2_errs", errs, 0);
    check_eq("s2_held", int'(held), 0);

    // simultaneous UP+DOWN gives error, then no click until all released
    start(4'b0101);
    run(20);
    check_eq("s3_errs", errs, 1);
    check_eq("s3_err_edge", first_err, 7);
    check_eq("s3_clicks", clicks, 0);
    check_eq("s3_dir", int'(direction_out), 1);
    keys = 4'b0001;
    run(20);
    check_eq("s3_partial_release_clicks", clicks, 0);
    keys = 4'b0000;
    run(12);

    // UP held, DOWN added and ignored, UP released first
    start(4'b0001);
    run(8);
    check_eq("s4_click_edge", first_click, 7);
    check_eq("s4_dir", int'(direction_out), 0);
    enable = 1'b0;
    keys = 4'b0101;
    run(15);
    check_eq("s4_second_key_held", int'(held), 1);
    keys = 4'b0100;
    run(15);
    check_eq("s4_held_after_up_release", int'(held), 0);
    keys = 4'b0000;
    run(12);
    check_eq("s4_total_clicks", clicks, 1);
    check_eq("s4_errs", errs, 0);
    check_eq("s4_dir_kept", int'(direction_out), 0);

    // press while disabled, enable late, then reset while HELD
    enable = 1'b0;
    start(4'b0010);
    run(15);
    check_eq("s5_disabled_clicks", clicks, 0);
    enable = 1'b1;
    run(1);
    check_eq("s5_late_click_edge", first_click, 16);
    check_eq("s5_late_dir", int'(direction_out), 1);
    reset = 1'b1;
    #1;
    check_eq("s5_rst_clicked", int'(clicked), 0);
    check_eq("s5_rst_held", int'(held), 0);
    check_eq("s5_rst_dir", int'(direction_out), 0);
    check_eq("s5_rst_err", int'(error_multi), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    clear_stats();
    run(8);
    check_eq("s5_reclick_edge", first_click, 7);
    check_eq("s5_reclick_dir", int'(direction_out), 1);
    enable = 1'b0;
    keys = 4'b0000;
    run(12);
    enable = 1'b1;

    // LEFT held 40 cycles: repeats only when the feature is built in
    start(4'b1000);
    run(40);
`ifdef AUTO_REPEAT_EN
    check_eq("s6_clicks", clicks, 5);
    check_eq("s6_last_click_edge", last_click, 39);
`else
    check_eq("s6_clicks", clicks, 1);
    check_eq("s6_last_click_edge", last_click, 7);
`endif
    check_eq("s6_first_click_edge", first_click, 7);
    check_eq("s6_dir", int'(direction_out), 3);
    keys = 4'b0000;
    run(12);
    check_eq("s6_held_released", int'(held), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
